// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: round-robin picks one resident warp and walks it through
// fetch/decode/regs/execute/memory/writeback, owning each warp's PC and retire flag.
package warp_scheduler_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST,
    WARP_EXECUTE, WARP_WAIT, WARP_UPDATE, WARP_DONE
  } warp_state_t;
endpackage

// Per-warp context: PC and retire flag.
module warp_ctx (
  input  logic        clk,
  input  logic        reset,
  input  logic        launch,
  input  logic        active,
  input  logic        upd,
  input  logic        set_done,
  input  logic [31:0] start_pc,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        done_flag
);
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      done_flag <= 1'b0;
    end else if (launch) begin
      pc        <= start_pc;
      done_flag <= ~active;
    end else if (upd) begin
      pc <= next_pc;
      if (set_done) done_flag <= 1'b1;
    end
  end
endmodule

module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS        = 4,
  parameter int THREADS_PER_WARP = 8,
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_WARPS-1:0]        warp_mask,
  input  logic [31:0]                 start_pc,
  output logic                        fetch_req,
  input  logic                        fetch_ack,
  input  logic                        DMemEN,
  input  logic                        is_ret,
  output logic                        lsu_req,
  input  logic                        lsu_done,
  input  logic [31:0]                 next_pc,
  output logic [WW-1:0]               cur_warp,
  output logic [31:0]                 cur_pc,
  output warp_state_t                 warp_state,
  output logic [NUM_WARPS-1:0]        warp_enable,
  output logic [THREADS_PER_WARP-1:0] thread_enable,
  output logic                        done
);
  warp_state_t                 state_q, state_d;
  logic [WW-1:0]               cur_warp_q, cur_warp_d;
  logic                        dmem_q, ret_q, launch, busy;
  logic [NUM_WARPS-1:0]        cur_oh, upd_oh, done_flags, flags_post;
  logic [NUM_WARPS-1:0][31:0]  pc;
  int                          idx;

  assign cur_oh     = NUM_WARPS'(1) << cur_warp_q;
  assign busy       = (state_q != WARP_IDLE) && (state_q != WARP_DONE);
  assign upd_oh     = (state_q == WARP_UPDATE) ? cur_oh : '0;
  // Scan uses the flags as they will be after this UPDATE retires the warp.
  assign flags_post = done_flags | (ret_q ? cur_oh : '0);

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    warp_ctx u_ctx (
      .clk      (clk),
      .reset    (reset),
      .launch   (launch),
      .active   (warp_mask[w]),
      .upd      (upd_oh[w]),
      .set_done (ret_q),
      .start_pc (start_pc),
      .next_pc  (next_pc),
      .pc       (pc[w]),
      .done_flag(done_flags[w])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WARP_IDLE;
      cur_warp_q <= '0;
      dmem_q     <= 1'b0;
      ret_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_warp_q <= cur_warp_d;
      if (state_q == WARP_DECODE) begin
        dmem_q <= DMemEN;
        ret_q  <= is_ret;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_warp_d = cur_warp_q;
    launch     = 1'b0;
    idx        = 0;
    case (state_q)
      WARP_IDLE, WARP_DONE:
        if (start) begin
          if (warp_mask == '0) state_d = WARP_DONE;
          else begin
            launch  = 1'b1;
            state_d = WARP_FETCH;
            for (int i = NUM_WARPS - 1; i >= 0; i--)
              if (warp_mask[i]) cur_warp_d = WW'(i);
          end
        end
      WARP_FETCH:   if (fetch_ack) state_d = WARP_DECODE;
      WARP_DECODE:  state_d = WARP_REQUEST;
      WARP_REQUEST: state_d = WARP_EXECUTE;
      WARP_EXECUTE: state_d = dmem_q ? WARP_WAIT : WARP_UPDATE;
      WARP_WAIT:    if (lsu_done) state_d = WARP_UPDATE;
      WARP_UPDATE: begin
        state_d = WARP_DONE;
        // Descending scan so the nearest live warp after cur_warp wins.
        for (int i = NUM_WARPS; i >= 1; i--) begin
          idx = int'(cur_warp_q) + i;
          if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
          if (!flags_post[WW'(idx)]) begin
            state_d    = WARP_FETCH;
            cur_warp_d = WW'(idx);
          end
        end
      end
      default: state_d = WARP_IDLE;
    endcase
  end

  assign warp_state    = state_q;
  assign cur_warp      = cur_warp_q;
  assign cur_pc        = pc[cur_warp_q];
  assign fetch_req     = (state_q == WARP_FETCH);
  assign lsu_req       = (state_q == WARP_WAIT);
  assign warp_enable   = busy ? cur_oh : '0;
  assign thread_enable = '1;
  assign done          = (state_q == WARP_DONE);
endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler: expected (warp, pc) issues are queued at
// launch and popped as each instruction reaches FETCH.
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;
  localparam int NW = 4;
  localparam int TPW = 8;

  logic            clk = 1'b0;
  logic            reset, start, fetch_ack, DMemEN, is_ret, lsu_done;
  logic [NW-1:0]   warp_mask;
  logic [31:0]     start_pc, next_pc;
  logic            fetch_req, lsu_req, done;
  logic [1:0]      cur_warp;
  logic [31:0]     cur_pc;
  warp_state_t     warp_state;
  logic [NW-1:0]   warp_enable;
  logic [TPW-1:0]  thread_enable;

  typedef struct { logic [1:0] w; logic [31:0] pc; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  warp_scheduler #(.NUM_WARPS(NW), .THREADS_PER_WARP(TPW)) dut (
    .clk(clk), .reset(reset), .start(start), .warp_mask(warp_mask),
    .start_pc(start_pc), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .DMemEN(DMemEN), .is_ret(is_ret), .lsu_req(lsu_req), .lsu_done(lsu_done),
    .next_pc(next_pc), .cur_warp(cur_warp), .cur_pc(cur_pc),
    .warp_state(warp_state), .warp_enable(warp_enable),
    .thread_enable(thread_enable), .done(done)
  );

  always #5 clk = ~clk;
  // Branch unit stand-in: straight-line code.
  assign next_pc = cur_pc + 32'h4;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [NW-1:0] m, input logic [31:0] p);
    warp_mask = m; start_pc = p; start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc();
    checks++;
    if (warp_state !== WARP_IDLE || cur_warp !== 2'd0 || cur_pc !== 32'h0 ||
        warp_enable !== 4'h0 || fetch_req !== 1'b0 || lsu_req !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got st=%0d w=%0d pc=%h en=%b fr=%b lr=%b d=%b exp st=0 w=0 pc=0 en=0 fr=0 lr=0 d=0",
               warp_state, cur_warp, cur_pc, warp_enable, fetch_req, lsu_req, done);
    end
    checks++;
    if (thread_enable !== {TPW{1'b1}}) begin
      errors++; $display("FAIL thread_enable got %b exp all ones", thread_enable);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit hit = 0;
    do_reset();
    fetch_ack = 1'b1; DMemEN = 1'b1;
    pulse_start(4'b0001, 32'h40);
    for (int i = 0; i < 20 && !hit; i++) begin
      if (warp_state == WARP_WAIT) hit = 1; else cyc();
    end
    checks++;
    if (!hit || lsu_req !== 1'b1) begin
      errors++; $display("FAIL reach_wait got hit=%0d lsu_req=%b exp hit=1 lsu_req=1", hit, lsu_req);
    end
    reset = 1'b1; cyc(); reset = 1'b0;
    checks++;
    if (warp_state !== WARP_IDLE || lsu_req !== 1'b0 || warp_enable !== 4'h0 ||
        done !== 1'b0 || cur_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wait got st=%0d lr=%b en=%b d=%b pc=%h exp st=0 lr=0 en=0 d=0 pc=0",
               warp_state, lsu_req, warp_enable, done, cur_pc);
    end
    DMemEN = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] mpc [NW];
    logic [1:0]  order [3] = '{2'd0, 2'd1, 2'd3};
    exp_t e;
    do_reset();
    fetch_ack = 1'b1; DMemEN = 1'b0; is_ret = 1'b0;
    for (int w = 0; w < NW; w++) mpc[w] = 32'h100;
    for (int k = 0; k < 7; k++) begin
      sb.push_back('{order[k % 3], mpc[order[k % 3]]});
      mpc[order[k % 3]] += 32'h4;
    end
    pulse_start(4'b1011, 32'h100);
    for (int k = 0; k < 7; k++) begin
      e = sb.pop_front();
      checks++;
      if (warp_state !== WARP_FETCH || cur_warp !== e.w || cur_pc !== e.pc ||
          warp_enable !== (4'b0001 << e.w) || fetch_req !== 1'b1) begin
        errors++;
        $display("FAIL rr_issue%0d got st=%0d w=%0d pc=%h en=%b fr=%b exp st=1 w=%0d pc=%h",
                 k, warp_state, cur_warp, cur_pc, warp_enable, fetch_req, e.w, e.pc);
      end
      if (k < 6) repeat (5) cyc();
    end
  endtask

  task automatic test_mem_wait();
    int cycles = 0, waitc = 0, lr_bad = 0;
    exp_t e;
    do_reset();
    fetch_ack = 1'b1; DMemEN = 1'b1; is_ret = 1'b0;
    sb.push_back('{2'd0, 32'h404});
    lsu_done = 1'b1;                 // stray completion outside WAIT
    pulse_start(4'b0001, 32'h400);
    lsu_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(); cycles++;
      if (warp_state == WARP_WAIT) begin
        waitc++;
        if (lsu_req !== 1'b1) lr_bad++;
        lsu_done = (waitc == 3);
      end else lsu_done = 1'b0;
      if (warp_state == WARP_FETCH) break;
    end
    checks++;
    if (waitc != 3 || lr_bad != 0) begin
      errors++; $display("FAIL wait_len got wait=%0d lsu_req_low=%0d exp wait=3 lsu_req_low=0", waitc, lr_bad);
    end
    checks++;
    if (cycles != 8) begin
      errors++; $display("FAIL mem_instr_cycles got %0d exp 8", cycles);
    end
    e = sb.pop_front();
    checks++;
    if (warp_state !== WARP_FETCH || cur_warp !== e.w || cur_pc !== e.pc) begin
      errors++; $display("FAIL mem_next_pc got st=%0d w=%0d pc=%h exp st=1 w=%0d pc=%h",
                         warp_state, cur_warp, cur_pc, e.w, e.pc);
    end
    DMemEN = 1'b0;
  endtask

  task automatic test_fetch_stall();
    do_reset();
    fetch_ack = 1'b0; DMemEN = 1'b0;
    pulse_start(4'b0001, 32'h500);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (warp_state !== WARP_FETCH || fetch_req !== 1'b1 || cur_pc !== 32'h500) begin
        errors++; $display("FAIL fetch_hold%0d got st=%0d fr=%b pc=%h exp st=1 fr=1 pc=00000500",
                           i, warp_state, fetch_req, cur_pc);
      end
      if (i == 3) fetch_ack = 1'b1;
      cyc();
    end
    checks++;
    if (warp_state !== WARP_DECODE || fetch_req !== 1'b0) begin
      errors++; $display("FAIL fetch_release got st=%0d fr=%b exp st=2 fr=0", warp_state, fetch_req);
    end
  endtask

  task automatic test_ret_done();
    exp_t e;
    do_reset();
    fetch_ack = 1'b1; DMemEN = 1'b0; is_ret = 1'b1;
    sb.push_back('{2'd0, 32'h200});
    sb.push_back('{2'd2, 32'h200});
    pulse_start(4'b0101, 32'h200);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      checks++;
      if (warp_state !== WARP_FETCH || cur_warp !== e.w || cur_pc !== e.pc) begin
        errors++; $display("FAIL ret_issue%0d got st=%0d w=%0d pc=%h exp st=1 w=%0d pc=%h",
                           k, warp_state, cur_warp, cur_pc, e.w, e.pc);
      end
      repeat (5) cyc();
    end
    checks++;
    if (warp_state !== WARP_DONE || done !== 1'b1 || warp_enable !== 4'h0) begin
      errors++; $display("FAIL all_retired got st=%0d d=%b en=%b exp st=7 d=1 en=0", warp_state, done, warp_enable);
    end
    is_ret = 1'b0;
    pulse_start(4'b0101, 32'h300);
    checks++;
    if (warp_state !== WARP_FETCH || cur_warp !== 2'd0 || cur_pc !== 32'h300 || done !== 1'b0) begin
      errors++; $display("FAIL relaunch got st=%0d w=%0d pc=%h d=%b exp st=1 w=0 pc=00000300 d=0",
                         warp_state, cur_warp, cur_pc, done);
    end
  endtask

  task automatic test_empty_and_ignore();
    do_reset();
    fetch_ack = 1'b0;
    pulse_start(4'b0000, 32'h0);
    checks++;
    if (warp_state !== WARP_DONE || done !== 1'b1) begin
      errors++; $display("FAIL empty_mask got st=%0d d=%b exp st=7 d=1", warp_state, done);
    end
    pulse_start(4'b0010, 32'h600);
    checks++;
    if (warp_state !== WARP_FETCH || cur_warp !== 2'd1 || cur_pc !== 32'h600 || warp_enable !== 4'b0010) begin
      errors++; $display("FAIL lowest_bit got st=%0d w=%0d pc=%h en=%b exp st=1 w=1 pc=00000600 en=0010",
                         warp_state, cur_warp, cur_pc, warp_enable);
    end
    pulse_start(4'b0001, 32'h700);
    checks++;
    if (warp_state !== WARP_FETCH || cur_warp !== 2'd1 || cur_pc !== 32'h600) begin
      errors++; $display("FAIL start_ignored got st=%0d w=%0d pc=%h exp st=1 w=1 pc=00000600",
                         warp_state, cur_warp, cur_pc);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; warp_mask = '0; start_pc = '0;
    fetch_ack = 1'b0; DMemEN = 1'b0; is_ret = 1'b0; lsu_done = 1'b0;
    test_reset();
    test_reset_mid_wait();
    test_round_robin();
    test_mem_wait();
    test_fetch_stall();
    test_ret_done();
    test_empty_and_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
